md5unit_sched: RTL and testbench

//  Parametrised core scheduler/collector for an MD5 unit: N_CORES cores x THREADS_PER_CORE contexts.

---
 rtl/md5unit_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_md5unit_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5unit_sched.sv
// MD5 unit scheduler/collector: loads 16-word blocks into free (core,ctx) slots round-robin
// and drains per-core result FIFOs as whole, non-interleaved bursts.
module md5unit_sched #(
    parameter int unsigned N_CORES          = 3,
    parameter int unsigned THREADS_PER_CORE = 4,
    parameter int unsigned BLK_OP_W         = 4,
    parameter int unsigned OUT_WORDS        = 4,
    parameter int unsigned OUT_DEPTH        = 8,
    localparam int unsigned CTX_W  = $clog2(THREADS_PER_CORE),
    localparam int unsigned CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                                 CLK,
    input  logic                                 RESET_N,
    input  logic [31:0]                          in_data,
    input  logic [BLK_OP_W-1:0]                  in_blk_op,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_CORES*THREADS_PER_CORE-1:0]  core_ready,
    output logic [N_CORES-1:0]                   core_wr_en,
    output logic [31:0]                          core_din,
    output logic [3:0]                           core_wr_addr,
    output logic [CTX_W-1:0]                     core_ctx_num,
    output logic [BLK_OP_W-1:0]                  core_blk_op,
    output logic [N_CORES-1:0]                   core_start,
    input  logic [32*N_CORES-1:0]                core_dout,
    input  logic [N_CORES-1:0]                   core_dout_en,
    input  logic [N_CORES*CTX_W-1:0]             core_dout_ctx,
    output logic [31:0]                          out_data,
    output logic [CORE_W-1:0]                    out_core,
    output logic [CTX_W-1:0]                     out_ctx,
    output logic                                 out_valid,
    output logic                                 out_last,
    input  logic                                 out_ready,
    output logic [N_CORES-1:0]                   err
);
    localparam int unsigned SLOTS  = N_CORES * THREADS_PER_CORE;
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned AW     = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W  = AW + 1;
    localparam int unsigned OW_W   = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    typedef enum logic [2:0] {StIdle, StSelect, StLoad, StStart, StHold} state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   rr_q, slot_q, pick;
    logic                pick_found;
    logic [3:0]          cnt_q;
    logic                hold_q;
    logic [BLK_OP_W-1:0] blk_op_q;
    logic [CORE_W-1:0]   ld_core;
    logic [CTX_W-1:0]    ld_ctx;
    logic                wr_word;
    int unsigned         idx;

    assign ld_core = CORE_W'(slot_q >> CTX_W);
    assign ld_ctx  = slot_q[CTX_W-1:0];
    assign wr_word = (state_q == StLoad) && in_valid;

    // First ready slot at or after the round-robin pointer; descending loop so lowest offset wins.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % SLOTS;
            if (core_ready[SLOT_W'(idx)]) begin
                pick       = SLOT_W'(idx);
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_valid) state_d = StSelect;
            StSelect: if (pick_found) state_d = StLoad;
            StLoad:   if (in_valid && cnt_q == 4'd15) state_d = StStart;
            StStart:  state_d = StHold;
            StHold:   if (hold_q) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rr_q     <= '0;
            slot_q   <= '0;
            cnt_q    <= '0;
            hold_q   <= 1'b0;
            blk_op_q <= '0;
        end else begin
            if (state_q == StSelect && pick_found) slot_q <= pick;
            if (wr_word) cnt_q <= cnt_q + 4'd1;
            if (wr_word && cnt_q == 4'd0) blk_op_q <= in_blk_op;
            if (state_q == StStart)
                rr_q <= (slot_q == SLOT_W'(SLOTS - 1)) ? '0 : slot_q + 1'b1;
            hold_q <= (state_q == StHold) ? ~hold_q : 1'b0;
        end
    end

    always_comb begin
        in_ready     = (state_q == StLoad);
        core_wr_en   = wr_word ? (N_CORES'(1) << ld_core) : '0;
        core_din     = wr_word ? in_data : '0;
        core_wr_addr = cnt_q;
        core_ctx_num = ld_ctx;
        core_blk_op  = (state_q == StLoad && cnt_q == 4'd0) ? in_blk_op : blk_op_q;
        core_start   = (state_q == StStart) ? (N_CORES'(1) << ld_core) : '0;
    end

    // Result FIFOs: pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [31:0]       mem_q     [N_CORES][OUT_DEPTH];
    logic [CTX_W-1:0]  ctx_mem_q [N_CORES][OUT_DEPTH];
    logic [CNT_W-1:0]  wptr_q [N_CORES];
    logic [CNT_W-1:0]  rptr_q [N_CORES];
    logic [CNT_W-1:0]  fcnt   [N_CORES];
    logic [OW_W-1:0]   in_beat_q [N_CORES];
    logic [CTX_W-1:0]  cap_ctx_q [N_CORES];
    logic [CTX_W-1:0]  push_ctx  [N_CORES];
    logic [N_CORES-1:0] full, avail, push, pop, err_q;

    always_comb begin
        for (int c = 0; c < N_CORES; c++) begin
            fcnt[c]     = wptr_q[c] - rptr_q[c];
            full[c]     = (fcnt[c] == CNT_W'(OUT_DEPTH));
            avail[c]    = (fcnt[c] >= CNT_W'(OUT_WORDS));
            push[c]     = core_dout_en[c] && !full[c];
            push_ctx[c] = (in_beat_q[c] == '0) ? core_dout_ctx[c*CTX_W +: CTX_W] : cap_ctx_q[c];
        end
    end

    always_ff @(posedge CLK) begin
        for (int c = 0; c < N_CORES; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c][AW-1:0]]     <= core_dout[c*32 +: 32];
                ctx_mem_q[c][wptr_q[c][AW-1:0]] <= push_ctx[c];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < N_CORES; c++) begin
                wptr_q[c]    <= '0;
                rptr_q[c]    <= '0;
                in_beat_q[c] <= '0;
                cap_ctx_q[c] <= '0;
            end
            err_q <= '0;
        end else begin
            for (int c = 0; c < N_CORES; c++) begin
                if (push[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
                if (pop[c])  rptr_q[c] <= rptr_q[c] + 1'b1;
                if (core_dout_en[c]) begin
                    in_beat_q[c] <= (in_beat_q[c] == OW_W'(OUT_WORDS - 1)) ? '0
                                                                            : in_beat_q[c] + 1'b1;
                    if (in_beat_q[c] == '0) cap_ctx_q[c] <= core_dout_ctx[c*CTX_W +: CTX_W];
                    if (full[c]) err_q[c] <= 1'b1;
                end
            end
        end
    end

    // Drain: once a core is granted, its whole burst goes out before anyone else is considered.
    logic [CORE_W-1:0] rr_out_q, gcore_q, arb_core, sel;
    logic [OW_W-1:0]   out_beat_q;
    logic              busy_q, arb_found, load, beat_last;
    int unsigned       aidx;

    always_comb begin
        arb_core  = '0;
        arb_found = 1'b0;
        aidx      = 0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            aidx = (int'(rr_out_q) + i) % N_CORES;
            if (avail[aidx]) begin
                arb_core  = CORE_W'(aidx);
                arb_found = 1'b1;
            end
        end
        sel       = busy_q ? gcore_q : arb_core;
        load      = (busy_q || arb_found) && (!out_valid || out_ready);
        beat_last = (out_beat_q == OW_W'(OUT_WORDS - 1));
        pop       = load ? (N_CORES'(1) << sel) : '0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rr_out_q   <= '0;
            gcore_q    <= '0;
            out_beat_q <= '0;
            busy_q     <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_core   <= '0;
            out_ctx    <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= mem_q[sel][rptr_q[sel][AW-1:0]];
            out_ctx    <= ctx_mem_q[sel][rptr_q[sel][AW-1:0]];
            out_core   <= sel;
            out_last   <= beat_last;
            out_beat_q <= beat_last ? '0 : out_beat_q + 1'b1;
            busy_q     <= !beat_last;
            gcore_q    <= sel;
            if (!busy_q) rr_out_q <= (sel == CORE_W'(N_CORES - 1)) ? '0 : sel + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_md5unit_sched.sv
// Randomised scoreboard bench for md5unit_sched: load-side and result-side expectations are
// queued by stimulus and popped by independent monitors.
module tb_md5unit_sched;
    localparam int N = 3, T = 4, OPW = 4, S = 12, CW = 2, XW = 2;

    logic CLK = 1'b0, RESET_N = 1'b0;
    logic [31:0] in_data = '0;
    logic [OPW-1:0] in_blk_op = '0;
    logic in_valid = 1'b0, in_ready;
    logic [S-1:0] core_ready = '0;
    logic [N-1:0] core_wr_en, core_start, core_dout_en = '0, err;
    logic [31:0] core_din, out_data;
    logic [3:0] core_wr_addr;
    logic [XW-1:0] core_ctx_num, out_ctx;
    logic [OPW-1:0] core_blk_op;
    logic [32*N-1:0] core_dout = '0;
    logic [N*XW-1:0] core_dout_ctx = '0;
    logic [CW-1:0] out_core;
    logic out_valid, out_last, out_ready = 1'b0;

    md5unit_sched dut (
        .CLK(CLK), .RESET_N(RESET_N), .in_data(in_data), .in_blk_op(in_blk_op),
        .in_valid(in_valid), .in_ready(in_ready), .core_ready(core_ready),
        .core_wr_en(core_wr_en), .core_din(core_din), .core_wr_addr(core_wr_addr),
        .core_ctx_num(core_ctx_num), .core_blk_op(core_blk_op), .core_start(core_start),
        .core_dout(core_dout), .core_dout_en(core_dout_en), .core_dout_ctx(core_dout_ctx),
        .out_data(out_data), .out_core(out_core), .out_ctx(out_ctx), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct { int core; int ctx; int addr; logic [31:0] data; } wr_t;
    typedef struct { int core; logic [OPW-1:0] op; } st_t;
    typedef struct { int core; int ctx; logic [127:0] d; } burst_t;

    wr_t    wr_q[$];
    st_t    st_q[$];
    burst_t out_q[$];
    int     order_q[$];
    int     outstanding[N];
    int     model_rr = 0;
    int     checks = 0, failures = 0;
    int     mon_beat = 0;
    burst_t cur;
    bit     rand_done = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pick_slot(input logic [S-1:0] v);
        for (int i = 0; i < S; i++) if (v[(model_rr + i) % S]) return (model_rr + i) % S;
        return -1;
    endfunction

    // Load-side and start monitors
    always @(negedge CLK) begin : mon_load
        wr_t e;
        st_t s;
        if (RESET_N) begin
            if (core_wr_en != 0) begin
                if (wr_q.size() == 0) check(0, "unexpected_wr", 64'(core_wr_en), 0);
                else begin
                    e = wr_q.pop_front();
                    check(core_wr_en === N'(1 << e.core) && core_din === e.data &&
                          core_wr_addr === 4'(e.addr) && core_ctx_num === XW'(e.ctx),
                          "load_word", {core_wr_en, core_ctx_num, core_wr_addr, core_din},
                          {N'(1 << e.core), XW'(e.ctx), 4'(e.addr), e.data});
                end
            end
            if (core_start != 0) begin
                if (st_q.size() == 0) check(0, "unexpected_start", 64'(core_start), 0);
                else begin
                    s = st_q.pop_front();
                    check(core_start === N'(1 << s.core) && core_blk_op === s.op, "start",
                          {core_start, core_blk_op}, {N'(1 << s.core), s.op});
                end
            end
        end
    end

    // Result monitor: a burst is matched to the oldest pending burst of its source core
    always @(negedge CLK) begin : mon_out
        int k;
        if (RESET_N && out_valid && out_ready) begin
            if (mon_beat == 0) begin
                k = -1;
                for (int i = 0; i < out_q.size(); i++)
                    if (k < 0 && out_q[i].core == int'(out_core)) k = i;
                if (k < 0) begin
                    check(0, "unexpected_burst", 64'(out_core), 0);
                    cur.core = -1;
                end else begin
                    cur = out_q[k];
                    out_q.delete(k);
                    order_q.push_back(int'(out_core));
                end
            end
            if (cur.core >= 0) begin
                check(out_data === cur.d[mon_beat*32 +: 32] && out_core === CW'(cur.core) &&
                      out_ctx === XW'(cur.ctx) && out_last === (mon_beat == 3), "out_word",
                      {out_last, out_core, out_ctx, out_data},
                      {mon_beat == 3, CW'(cur.core), XW'(cur.ctx),
                       cur.d[mon_beat*32 +: 32]});
                outstanding[cur.core]--;
            end
            mon_beat = (mon_beat + 1) % 4;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        in_valid = 1'b0;
        core_dout_en = '0;
        repeat (3) tick();
        model_rr = 0;
        mon_beat = 0;
        for (int c = 0; c < N; c++) outstanding[c] = 0;
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic wait_accept();
        int n = 0;
        bit ok = 0;
        do begin
            @(negedge CLK);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 300);
        if (!ok) check(0, "accept_timeout", 0, 1);
    endtask

    task automatic send_block(input logic [S-1:0] vec, input int nwords, input bit gaps,
                              input bit seq_data);
        int slot;
        logic [OPW-1:0] op;
        logic [31:0] w[16];
        core_ready = vec;
        slot = pick_slot(vec);
        op = OPW'($urandom);
        for (int i = 0; i < 16; i++) w[i] = seq_data ? 32'(i) : $urandom;
        for (int i = 0; i < nwords; i++) wr_q.push_back('{slot / T, slot % T, i, w[i]});
        if (nwords == 16) begin
            st_q.push_back('{slot / T, op});
            model_rr = (slot + 1) % S;
        end
        for (int i = 0; i < nwords; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data = w[i];
            in_blk_op = (i == 0) ? op : OPW'($urandom);
            wait_accept();
        end
        in_valid = 1'b0;
    endtask

    task automatic emit(input logic [N-1:0] mask, input bit expect_out);
        logic [127:0] d[N];
        int cx[N];
        for (int c = 0; c < N; c++) begin
            d[c] = {$urandom, $urandom, $urandom, $urandom};
            cx[c] = $urandom_range(T - 1);
            if (mask[c] && expect_out) begin
                out_q.push_back('{c, cx[c], d[c]});
                outstanding[c] += 4;
            end
        end
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < N; c++) begin
                core_dout_en[c] = mask[c];
                core_dout[c*32 +: 32] = d[c][b*32 +: 32];
                core_dout_ctx[c*XW +: XW] = (b == 0) ? XW'(cx[c]) : XW'($urandom);
            end
            tick();
        end
        core_dout_en = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((out_q.size() != 0 || wr_q.size() != 0 || st_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        repeat (8) tick();
        check(out_q.size() == 0 && wr_q.size() == 0 && st_q.size() == 0 && mon_beat == 0,
              name, 64'(out_q.size() + wr_q.size() + st_q.size()), 0);
    endtask

    initial begin
        repeat (2) tick();
        RESET_N = 1'b1;
        tick();
        check({in_ready, core_wr_en, core_start, out_valid, out_last, err} === '0, "reset_outs",
              {in_ready, core_wr_en, core_start, out_valid, out_last, err}, 0);

        // 1: single block, sequential data, all slots free
        send_block('1, 16, 0, 1);
        wait_idle("t1_block");

        // 4: simultaneous bursts from cores 0 and 2
        out_ready = 1'b1;
        order_q.delete();
        emit(3'b101, 1);
        wait_idle("t4_drain");
        check(order_q.size() == 2 && order_q[0] == 0 && order_q[1] == 2, "t4_rr_order",
              {32'(order_q.size()), 16'(order_q[0]), 16'(order_q[1])}, {32'd2, 16'd0, 16'd2});

        // 2: thirteen back-to-back blocks walk every slot then wrap
        do_reset();
        for (int b = 0; b < 13; b++) send_block('1, 16, 0, 0);
        wait_idle("t2_blocks");

        // 3: nothing free, then only core 1 ctx 0
        core_ready = '0;
        in_valid = 1'b1;
        in_data = $urandom;
        repeat (6) tick();
        @(negedge CLK);
        check(in_ready === 1'b0, "t3_select_wait", 64'(in_ready), 0);
        tick();
        send_block(12'h010, 16, 0, 0);
        wait_idle("t3_block");

        // Random: blocks with gaps and random slot masks alongside random result traffic
        fork
            begin
                logic [S-1:0] v;
                for (int b = 0; b < 12; b++) begin
                    do v = S'($urandom); while (v == 0);
                    send_block(v, 16, 1, 0);
                end
            end
            begin
                logic [N-1:0] m;
                for (int k = 0; k < 40; k++) begin
                    m = '0;
                    for (int c = 0; c < N; c++)
                        if (outstanding[c] <= 4 && $urandom_range(1) == 1) m[c] = 1'b1;
                    if (m != 0) emit(m, 1);
                    else tick();
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_idle("rand_drain");
        check(err === '0, "rand_no_err", 64'(err), 0);

        // 5: overflow on core 1 with output stalled
        out_ready = 1'b0;
        emit(3'b010, 1);
        emit(3'b010, 1);
        emit(3'b010, 0);
        repeat (3) tick();
        check(err === 3'b010, "t5_err", 64'(err), 64'h2);
        out_ready = 1'b1;
        wait_idle("t5_drain");
        check(out_valid === 1'b0, "t5_no_partial", 64'(out_valid), 0);

        // 6: reset in the middle of a block load
        do_reset();
        send_block('1, 7, 0, 0);
        RESET_N = 1'b0;
        tick();
        check({in_ready, out_valid, err, core_start} === '0, "t6_in_reset",
              {in_ready, out_valid, err, core_start}, 0);
        RESET_N = 1'b1;
        repeat (20) tick();
        check({in_ready, out_valid, err} === '0 && wr_q.size() == 0 && st_q.size() == 0,
              "t6_after_reset", {in_ready, out_valid, err, 8'(wr_q.size() + st_q.size())}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
